// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } lsu_state_t;

    localparam int EXU_W       = 109;
    localparam int LSU_W       = 38;
    localparam int ALU_LSB     = 77;
    localparam int RS2_LSB     = 45;
    localparam int MEM_REN_BIT = 44;
    localparam int MEM_WEN_BIT = 43;
    localparam int MEM_OP_LSB  = 40;
    localparam int RD_LSB      = 35;
    localparam int REG_WEN_BIT = 34;
    localparam int WB_SEL_LSB  = 32;
    localparam int CSR_LSB     = 0;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_CSR  = 2'b10;
    localparam logic [1:0] WB_ALU2 = 2'b11;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  mem_op;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  wb_sel;
        logic [31:0] csr_data;
    } exu_pkt_t;

    // Stores never write back data, whatever wb_sel says.
    function automatic logic [31:0] wb_select(input logic        is_store,
                                              input logic [1:0]  wb_sel,
                                              input logic [31:0] load_val,
                                              input logic [31:0] csr_val,
                                              input logic [31:0] alu_val);
        logic [31:0] r;
        case (wb_sel)
            WB_MEM:          r = load_val;
            WB_CSR:          r = csr_val;
            WB_ALU, WB_ALU2: r = alu_val;
            default:         r = alu_val;
        endcase
        return is_store ? 32'h0 : r;
    endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// Byte-lane alignment: store mask/data placement, load extract/extend, misalign detect.
// Purely combinational, zero latency; no flow control.
// Backpressure: none, outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        wmask     = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;
        misalign  = 1'b0;
        shifted   = rdata >> {offset, 3'b000};

        case (mem_op[1:0])
            SZ_BYTE: begin
                wmask = 4'b0001 << offset;
                wdata = {4{rs2_data[7:0]}};
            end
            SZ_HALF: begin
                wmask    = 4'b0011 << offset;
                wdata    = {2{rs2_data[15:0]}};
                misalign = offset[0];
            end
            SZ_WORD: begin
                wmask    = 4'b1111;
                wdata    = rs2_data;
                misalign = (offset != 2'b00);
            end
            default: ;
        endcase

        case (mem_op)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0, shifted[15:0]};
            OP_LW:   load_data = shifted;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one packet in flight, one memory access per load/store.
// Latency: 1 cycle for non-memory packets, 2 + req stall + rsp wait for memory packets.
// Backpressure: lsu_ready only in idle; output packet held until wbu_ready.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    input  logic [EXU_W-1:0]  exu_data,
    output logic              lsu_ready,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [WIDTH-1:0]  req_addr,
    output logic [WIDTH-1:0]  req_wdata,
    output logic [3:0]        req_wmask,
    input  logic              rsp_valid,
    input  logic [WIDTH-1:0]  rsp_rdata,
    output logic              lsu_valid,
    output logic [LSU_W-1:0]  lsu_data,
    input  logic              wbu_ready,
    output logic              misalign
);

    lsu_state_t  state;
    exu_pkt_t    in_pkt;
    exu_pkt_t    pkt;
    exu_pkt_t    src;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_mis;
    logic        in_mem;
    logic [31:0] load_val;

    always_comb begin
        in_pkt.alu_result = exu_data[ALU_LSB +: 32];
        in_pkt.rs2_data   = exu_data[RS2_LSB +: 32];
        in_pkt.mem_ren    = exu_data[MEM_REN_BIT];
        in_pkt.mem_wen    = exu_data[MEM_WEN_BIT];
        in_pkt.mem_op     = exu_data[MEM_OP_LSB +: 3];
        in_pkt.rd         = exu_data[RD_LSB +: 5];
        in_pkt.reg_wen    = exu_data[REG_WEN_BIT];
        in_pkt.wb_sel     = exu_data[WB_SEL_LSB +: 2];
        in_pkt.csr_data   = exu_data[CSR_LSB +: 32];
    end

    // In idle the aligner looks at the incoming packet so the request can be
    // registered at accept; afterwards it works on the latched packet.
    assign src      = (state == S_IDLE) ? in_pkt : pkt;
    assign in_mem   = in_pkt.mem_ren | in_pkt.mem_wen;
    assign load_val = (pkt.mem_ren & ~pkt.mem_wen) ? al_load : 32'h0;

    lsu_align u_align (
        .mem_op    (src.mem_op),
        .offset    (src.alu_result[1:0]),
        .rs2_data  (src.rs2_data),
        .rdata     (rsp_rdata),
        .wmask     (al_wmask),
        .wdata     (al_wdata),
        .load_data (al_load),
        .misalign  (al_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pkt       <= '0;
            lsu_ready <= 1'b1;
            req_valid <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= 4'b0000;
            lsu_valid <= 1'b0;
            lsu_data  <= '0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (exu_valid) begin
                        pkt       <= in_pkt;
                        lsu_ready <= 1'b0;
                        req_wen   <= in_pkt.mem_wen;
                        req_addr  <= {in_pkt.alu_result[WIDTH-1:2], 2'b00};
                        req_wdata <= in_pkt.mem_wen ? al_wdata : '0;
                        req_wmask <= in_pkt.mem_wen ? al_wmask : 4'b0000;
                        if (in_mem && !al_mis) begin
                            req_valid <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            // Misaligned accesses skip memory and suppress write-back.
                            lsu_valid <= 1'b1;
                            lsu_data  <= {wb_select(in_pkt.mem_wen, in_pkt.wb_sel, 32'h0,
                                                    in_pkt.csr_data, in_pkt.alu_result),
                                          in_pkt.rd, in_pkt.reg_wen & ~(in_mem & al_mis)};
                            misalign  <= in_mem & al_mis;
                            state     <= S_OUT;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        lsu_valid <= 1'b1;
                        lsu_data  <= {wb_select(pkt.mem_wen, pkt.wb_sel, load_val,
                                                pkt.csr_data, pkt.alu_result),
                                      pkt.rd, pkt.reg_wen};
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (wbu_ready) begin
                        lsu_valid <= 1'b0;
                        lsu_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: directed packets, expected outputs queued, monitor compares.
module tb_lsu_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         exu_valid = 1'b0;
    logic [108:0] exu_data = '0;
    logic         lsu_ready;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic         req_wen;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wmask;
    logic         rsp_valid = 1'b0;
    logic [31:0]  rsp_rdata = '0;
    logic         lsu_valid;
    logic [37:0]  lsu_data;
    logic         wbu_ready = 1'b1;
    logic         misalign;

    always #5 clk = ~clk;

    lsu_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .exu_data(exu_data),
        .lsu_ready(lsu_ready), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .lsu_valid(lsu_valid), .lsu_data(lsu_data), .wbu_ready(wbu_ready),
        .misalign(misalign)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    logic [37:0] exp_out[$];
    req_t        exp_req[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          mis_cnt = 0;
    logic        mis_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected none", name, act);
    endtask

    function automatic logic [108:0] mk(input logic [31:0] alu, input logic [31:0] rs2,
                                        input logic ren, input logic wen, input logic [2:0] op,
                                        input logic [4:0] rd, input logic rwen,
                                        input logic [1:0] wsel, input logic [31:0] csr);
        return {alu, rs2, ren, wen, op, rd, rwen, wsel, csr};
    endfunction

    // Monitor: compares every presented output against the scoreboard queues.
    initial begin
        req_t r;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (lsu_valid && wbu_ready) begin
                    if (exp_out.size() == 0) flag("unexpected_out", lsu_data);
                    else begin
                        e = exp_out.pop_front();
                        check("lsu_data", lsu_data, e);
                    end
                end
                if (req_valid) begin
                    if (exp_req.size() == 0) flag("unexpected_req", req_addr);
                    else if (req_ready) begin
                        r = exp_req.pop_front();
                        check("req_addr", req_addr, r.addr);
                        check("req_wen", req_wen, r.wen);
                        check("req_wmask", req_wmask, r.wmask);
                        if (r.wen) check("req_wdata", req_wdata, r.wdata);
                    end
                end
                if (misalign) begin
                    if (mis_prev) flag("misalign_width", 2);
                    mis_cnt++;
                end
                mis_prev = misalign;
            end else begin
                mis_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [108:0] d);
        int n = 0;
        while (!lsu_ready && n < 50) begin tick(); n++; end
        if (!lsu_ready) flag("send_timeout", n);
        exu_valid = 1'b1;
        exu_data  = d;
        tick();
        exu_valid = 1'b0;
    endtask

    task automatic serve(input int stall, input int waitc, input logic [31:0] rdata);
        int n = 0;
        while (!req_valid && n < 50) begin tick(); n++; end
        if (!req_valid) begin
            flag("req_timeout", n);
            return;
        end
        repeat (stall) tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (waitc) tick();
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_out.size() != 0 || exp_req.size() != 0) && n < 50) begin tick(); n++; end
        if (exp_out.size() != 0 || exp_req.size() != 0) flag("drain_timeout", exp_out.size());
    endtask

    task automatic mem_test(input string name, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic ren, input logic wen, input logic [2:0] op,
                            input logic [4:0] rd, input logic [1:0] wsel,
                            input int stall, input int waitc, input logic [31:0] rdata,
                            input logic [3:0] e_mask, input logic [31:0] e_wdata,
                            input logic [31:0] e_wb);
        req_t r;
        r.wen   = wen;
        r.addr  = {alu[31:2], 2'b00};
        r.wdata = e_wdata;
        r.wmask = e_mask;
        exp_req.push_back(r);
        exp_out.push_back({e_wb, rd, 1'b1});
        send(mk(alu, rs2, ren, wen, op, rd, 1'b1, wsel, 32'h5555_AAAA));
        serve(stall, waitc, rdata);
        check({name, "_lat"}, lsu_valid, 1'b1);
        drain();
    endtask

    logic [37:0] exp_a;

    initial begin
        repeat (3) tick();
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_lsu_valid", lsu_valid, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_lsu_data", lsu_data, 38'h0);
        check("rst_req_wmask", req_wmask, 4'h0);
        check("rst_misalign", misalign, 1'b0);
        rst = 1'b1;
        tick();

        // Plain ALU packet: valid the cycle after accept, no memory request.
        exp_out.push_back({32'h0000_1234, 5'd5, 1'b1});
        send(mk(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 2'b00, 32'h0));
        check("alu_lat", lsu_valid, 1'b1);
        drain();

        exp_out.push_back({32'hCAFE_F00D, 5'd6, 1'b1});
        send(mk(32'h0000_0001, 32'h0, 1'b0, 1'b0, 3'b000, 5'd6, 1'b1, 2'b10, 32'hCAFE_F00D));
        drain();

        //       name   alu           rs2           ren  wen  op      rd     wsel   st wt rdata         mask     wdata         wb
        mem_test("lb",  32'h8000_0003, 32'h0,        1'b1, 1'b0, 3'b000, 5'd7,  2'b01, 0, 3, 32'h80FF_0000, 4'b0000, 32'h0,        32'hFFFF_FF80);
        mem_test("sh",  32'h0000_0102, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 5'd3,  2'b00, 2, 0, 32'hDEAD_BEEF, 4'b1100, 32'hABCD_ABCD, 32'h0);
        mem_test("lh",  32'h0000_0012, 32'h0,        1'b1, 1'b0, 3'b001, 5'd4,  2'b01, 1, 0, 32'h8001_1234, 4'b0000, 32'h0,        32'hFFFF_8001);
        mem_test("lhu", 32'h0000_0012, 32'h0,        1'b1, 1'b0, 3'b101, 5'd4,  2'b01, 0, 1, 32'h8001_1234, 4'b0000, 32'h0,        32'h0000_8001);
        mem_test("lbu", 32'h0000_0021, 32'h0,        1'b1, 1'b0, 3'b100, 5'd8,  2'b01, 0, 0, 32'h0000_F100, 4'b0000, 32'h0,        32'h0000_00F1);
        mem_test("lw",  32'h0000_0040, 32'h0,        1'b1, 1'b0, 3'b010, 5'd10, 2'b01, 0, 1, 32'h1234_5678, 4'b0000, 32'h0,        32'h1234_5678);
        mem_test("sb",  32'h0000_0041, 32'h1234_56EF, 1'b0, 1'b1, 3'b000, 5'd11, 2'b00, 0, 0, 32'h0,         4'b0010, 32'hEFEF_EFEF, 32'h0);
        mem_test("sw2", 32'h0000_0044, 32'hCAFE_BABE, 1'b1, 1'b1, 3'b010, 5'd12, 2'b01, 0, 0, 32'h0,         4'b1111, 32'hCAFE_BABE, 32'h0);
        mem_test("lwa", 32'h0000_0048, 32'h0,        1'b1, 1'b0, 3'b010, 5'd13, 2'b00, 0, 0, 32'h9999_9999, 4'b0000, 32'h0,        32'h0000_0048);

        // Misaligned word load and half store: no request, pulse, reg_wen dropped.
        exp_out.push_back({32'h0, 5'd9, 1'b0});
        send(mk(32'h0000_2001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 2'b01, 32'h0));
        check("mis_pulse", misalign, 1'b1);
        check("mis_lsu_valid", lsu_valid, 1'b1);
        check("mis_no_req", req_valid, 1'b0);
        tick();
        check("mis_pulse_end", misalign, 1'b0);
        drain();
        exp_out.push_back({32'h0, 5'd2, 1'b0});
        send(mk(32'h0000_0103, 32'h1111, 1'b0, 1'b1, 3'b001, 5'd2, 1'b1, 2'b00, 32'h0));
        drain();
        check("mis_count", mis_cnt, 2);

        // Downstream stall: output held, next packet waits until the cycle after wbu_ready.
        wbu_ready = 1'b0;
        exp_a = {32'h0000_0AAA, 5'd14, 1'b1};
        exp_out.push_back(exp_a);
        send(mk(32'h0000_0AAA, 32'h0, 1'b0, 1'b0, 3'b000, 5'd14, 1'b1, 2'b00, 32'h0));
        exp_out.push_back({32'h0000_0BBB, 5'd15, 1'b1});
        exu_valid = 1'b1;
        exu_data  = mk(32'h0000_0BBB, 32'h0, 1'b0, 1'b0, 3'b000, 5'd15, 1'b1, 2'b00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_lsu_data", lsu_data, exp_a);
            check("stall_lsu_ready", lsu_ready, 1'b0);
            tick();
        end
        wbu_ready = 1'b1;
        tick();
        check("stall_release_ready", lsu_ready, 1'b1);
        check("stall_release_valid", lsu_valid, 1'b0);
        tick();
        exu_valid = 1'b0;
        check("stall_b_valid", lsu_valid, 1'b1);
        drain();

        // Reset while waiting on the response; a late response must be ignored.
        exp_req.push_back('{wen: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, wmask: 4'b0000});
        send(mk(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd16, 1'b1, 2'b01, 32'h0));
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        check("arst_lsu_valid", lsu_valid, 1'b0);
        check("arst_lsu_ready", lsu_ready, 1'b1);
        check("arst_req_valid", req_valid, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_rdata = 32'h7777_7777;
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_lsu_valid", lsu_valid, 1'b0);
            check("stray_lsu_ready", lsu_ready, 1'b1);
            tick();
        end

        exp_out.push_back({32'h0000_0777, 5'd17, 1'b1});
        send(mk(32'h0000_0777, 32'h0, 1'b0, 1'b0, 3'b000, 5'd17, 1'b1, 2'b00, 32'h0));
        drain();

        check("final_out_q", exp_out.size(), 0);
        check("final_req_q", exp_req.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
